// File: rtl/product_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : product_divider_pkg
// Purpose  : Shared types and constants for the product_divider block.
//            - state_e       : controller states (IDLE / RUN / DONE)
//            - DEFAULT_WIDTH : default divisor/remainder width
//            - LAT           : start-edge to out_valid latency, 2*WIDTH+1
// Revision : 1.0  initial release
// ============================================================================
package product_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int LAT           = 2 * DEFAULT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/product_divider_step.sv
`default_nettype none
// ============================================================================
// Module   : product_divider_step
// Purpose  : One combinational shift-subtract step of a restoring divider.
// Ports    : rem_in  [WIDTH-1:0] partial remainder entering the step
//            num_bit             next dividend bit shifted into the remainder
//            den     [WIDTH-1:0] divisor
//            rem_out [WIDTH-1:0] partial remainder leaving the step
//            q_bit               quotient bit resolved by this step
// Revision : 1.0  initial release
// ============================================================================
module product_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             num_bit,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The shifted remainder needs one extra bit before the compare.
  logic [WIDTH:0] rem_shift;

  always_comb begin
    rem_shift = {rem_in, num_bit};
    q_bit     = (rem_shift >= {1'b0, den});
    // The result is always below den, so WIDTH-bit arithmetic is exact
    // even when the dropped top bit of rem_shift was set.
    rem_out   = q_bit ? (rem_shift[WIDTH-1:0] - den) : rem_shift[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/product_divider.sv
`default_nettype none
// ============================================================================
// Module   : product_divider
// Purpose  : Iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit
//            divisor, one quotient bit per clock, start/busy/valid handshake.
// Ports    : clk, rst_n (async assert, active low)
//            in_start, in_num[2W], in_den[W]          request + operands
//            out_busy, out_valid                       handshake
//            out_quot[2W], out_rem[W], out_div0        registered results
//            out_ovf  (only with PRODUCT_DIVIDER_OVF_EN) quotient exceeds W bits
// Config   : `define PRODUCT_DIVIDER_OVF_EN to add out_ovf.
// Revision : 1.0  initial release
// ============================================================================
module product_divider
  import product_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_start,
  input  logic [2*WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0]   in_den,
  output logic               out_busy,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0]   out_rem,
  output logic               out_div0
`ifdef PRODUCT_DIVIDER_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  localparam int                CNT_W    = $clog2(2 * WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(2 * WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  // work_q starts as the dividend; each step shifts its MSB into the
  // remainder and the new quotient bit into its LSB, so after 2*WIDTH
  // steps it holds the complete quotient.
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     den_q, den_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [2*WIDTH-1:0]   out_quot_q, out_quot_d;
  logic [WIDTH-1:0]     out_rem_q, out_rem_d;
  logic                 out_div0_q, out_div0_d;
`ifdef PRODUCT_DIVIDER_OVF_EN
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 out_ovf_q, out_ovf_d;
`endif

  logic [WIDTH-1:0]     step_rem;
  logic                 step_q_bit;
  logic [2*WIDTH-1:0]   work_shift;

  product_divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .num_bit (work_q[2*WIDTH-1]),
    .den     (den_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  assign work_shift = {work_q[2*WIDTH-2:0], step_q_bit};

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      work_q     <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      out_div0_q <= 1'b0;
`ifdef PRODUCT_DIVIDER_OVF_EN
      ovf_pend_q <= 1'b0;
      out_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      work_q     <= work_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      out_div0_q <= out_div0_d;
`ifdef PRODUCT_DIVIDER_OVF_EN
      ovf_pend_q <= ovf_pend_d;
      out_ovf_q  <= out_ovf_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          state_d = (in_den == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (count_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values. Result registers load on the edge that enters
  // DONE, so they are already valid while out_valid is high.
  // --------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    work_d     = work_q;
    den_d      = den_q;
    rem_d      = rem_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    out_div0_d = out_div0_q;
`ifdef PRODUCT_DIVIDER_OVF_EN
    ovf_pend_d = ovf_pend_q;
    out_ovf_d  = out_ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_start) begin
          work_d  = in_num;
          den_d   = in_den;
          rem_d   = '0;
          count_d = '0;
          if (in_den == '0) begin
            out_quot_d = '1;
            out_rem_d  = in_num[WIDTH-1:0];
            out_div0_d = 1'b1;
`ifdef PRODUCT_DIVIDER_OVF_EN
            out_ovf_d  = 1'b0;
`endif
          end else begin
`ifdef PRODUCT_DIVIDER_OVF_EN
            // Quotient fits in WIDTH bits only if the high half is below den.
            ovf_pend_d = (in_num[2*WIDTH-1:WIDTH] >= in_den);
`endif
          end
        end
      end
      RUN: begin
        work_d  = work_shift;
        rem_d   = step_rem;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          count_d    = '0;
          out_quot_d = work_shift;
          out_rem_d  = step_rem;
          out_div0_d = 1'b0;
`ifdef PRODUCT_DIVIDER_OVF_EN
          out_ovf_d  = ovf_pend_q;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    out_busy  = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  assign out_quot = out_quot_q;
  assign out_rem  = out_rem_q;
  assign out_div0 = out_div0_q;
`ifdef PRODUCT_DIVIDER_OVF_EN
  assign out_ovf  = out_ovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/product_divider.md
# product_divider

Iterative restoring divider that undoes the 32x32 Karatsuba multiplier: it divides a 2*WIDTH-bit product by a WIDTH-bit divisor. It returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder. It uses a start/busy/valid handshake and resolves one quotient bit per clock. It sits alongside the multiplier in the arithmetic datapath, and the bench uses it to recover operands from products.

## Interface
- WIDTH, 32, divisor/remainder width; dividend and quotient are 2*WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_start  in  1  request; sampled only in IDLE.
- in_num  in  2*WIDTH  dividend.
- in_den  in  WIDTH  divisor.
- out_busy  out  1  high in RUN and DONE.
- out_valid  out  1  one-cycle pulse when results are updated.
- out_quot  out  2*WIDTH  quotient, registered.
- out_rem  out  WIDTH  remainder, registered.
- out_div0  out  1  last operation had in_den == 0.
- out_ovf  out  1  present only with PRODUCT_DIVIDER_OVF_EN (see Configuration).

## Operation
- States:
  - IDLE: in_start=1 latches in_num/in_den and goes to RUN. If in_den==0, it goes straight to DONE.
  - RUN: performs 2*WIDTH shift-subtract steps, one per cycle, under count 0..2*WIDTH-1. After the last step it goes to DONE.
  - DONE: drives out_valid=1 for one cycle, then returns to IDLE.
- Each RUN step:
  - rem' = {rem, dividend MSB}; rem is WIDTH+1 bits internally.
  - If rem' >= den: rem' -= den and the quotient bit is 1.
  - The quotient shifts in from the LSB.
- Divide-by-zero: out_quot = all ones, out_rem = in_num[WIDTH-1:0], out_div0 = 1.
- Otherwise out_div0 = 0 and out_quot*in_den + out_rem == in_num, with out_rem < in_den.
- out_quot, out_rem, out_div0 and out_ovf update only in the cycle out_valid is asserted. They hold until the next out_valid or reset.
- in_start while out_busy=1 is ignored; no queueing.
- Operands are latched at start; input changes during RUN have no effect.
- Reset (any time, including mid-RUN):
  - State goes to IDLE and count to 0.
  - out_busy, out_valid, out_div0 and out_ovf go to 0.
  - out_quot and out_rem go to 0.
  - The in-flight operation is discarded.

## Timing
- Start edge = cycle 0, with in_start sampled high in IDLE.
- Nonzero divisor:
  - out_busy=1 from cycle 1 to cycle 2*WIDTH+1.
  - out_valid=1 in cycle 2*WIDTH+1 (65 cycles for WIDTH=32).
  - Idle again at cycle 2*WIDTH+2.
- Zero divisor: out_valid in cycle 1, idle at cycle 2.
- Earliest back-to-back start: the cycle after out_valid. Throughput is one operation per 2*WIDTH+2 cycles.
- No combinational path from any input to any output.

## Configuration
- Macro: PRODUCT_DIVIDER_OVF_EN.
- Defined:
  - Adds the out_ovf port.
  - Set together with out_valid when in_den != 0 and in_num[2*WIDTH-1:WIDTH] >= in_den, meaning the quotient does not fit in WIDTH bits.
  - The quotient is still delivered in full.
  - Reset value is 0.
- Undefined: the out_ovf port and its logic are absent; all other behaviour and timing are identical.

## Structure
- Package product_divider_pkg holds:
  - the state enum: IDLE, RUN, DONE;
  - the default WIDTH constant;
  - the latency constant LAT = 2*WIDTH+1.
- One natural sub-module, product_divider_step: combinational single shift-subtract.
  - Inputs: rem, next dividend bit, den.
  - Outputs: new rem, quotient bit.
  - The top holds state, count and registers.

## Test plan
- Exact division: in_num=400, in_den=10, start → after 65 cycles out_valid=1, out_quot=40, out_rem=0, out_div0=0.
- Multiplier round-trip: in_num=6847984 (2132*3212), in_den=3212 → out_quot=2132, out_rem=0. Also in_num=100, in_den=7 → out_quot=14, out_rem=2.
- Divide by zero: in_num=0x1234, in_den=0 → out_valid in cycle 1, out_div0=1, out_quot=64'hFFFF_FFFF_FFFF_FFFF, out_rem=0x1234.
- Busy ignore: start 400/10, pulse in_start with 9/3 at cycle 20 → a single out_valid at cycle 65 with out_quot=40. The next start, 9/3, gives out_quot=3.
- Reset mid-operation: drop rst_n at cycle 30 of a run, release it, start 20/4 → no stale out_valid from the aborted run, all outputs 0 during reset, then out_quot=5, out_rem=0.
- Overflow (with PRODUCT_DIVIDER_OVF_EN): in_num=2^40, in_den=1 → out_ovf=1, out_quot=2^40. Then 400/10 → out_ovf=0.
